// File: rtl/mxbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mxbus_pkg
//  Description : Shared types and default widths for the MXBUS responder.
//                Holds the responder state encoding, the default address /
//                length / data widths and the beat bundle type.
//  Revision    : 1.0  initial release
// ============================================================================
package mxbus_pkg;

    localparam int AW = 6;   // address width, register file depth 2**AW
    localparam int LW = 6;   // length width, length 0 encodes 2**LW beats
    localparam int DW = 32;  // data width, one strobe bit per byte

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        ACK  = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strobe;
    } beat_t;

endpackage : mxbus_pkg
`default_nettype wire

// File: rtl/mxbus_resp_mem.sv
`default_nettype none
// ============================================================================
//  Module      : mxbus_resp_mem
//  Description : 2**AW x DW register file with one byte-strobed write port
//                and one registered read port. Whole array clears on reset.
//  Ports       : clk, rst_n          clock, async active-low clear
//                wr_en/wr_addr       write enable and address
//                wr_data/wr_strobe   write data and byte enables
//                rd_addr/rd_data     read address, registered read data
//  Revision    : 1.0  initial release
// ============================================================================
module mxbus_resp_mem #(
    parameter int AW = mxbus_pkg::AW,
    parameter int DW = mxbus_pkg::DW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic [DW/8-1:0] wr_strobe,
    input  logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   rd_data
);

    localparam int C_DEPTH = 2 ** AW;
    localparam int C_NB    = DW / 8;

    logic [DW-1:0] mem_q [C_DEPTH];
    logic [DW-1:0] mem_d [C_DEPTH];
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_data_d;
    logic [DW-1:0] merged_w;

    // Bytes without a strobe keep the currently stored value.
    for (genvar b = 0; b < C_NB; b++) begin : g_lane
        assign merged_w[b*8 +: 8] = wr_strobe[b] ? wr_data[b*8 +: 8]
                                                 : mem_q[wr_addr][b*8 +: 8];
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = merged_w;
        end
        // Read from the pre-write array: a same-cycle write is not visible.
        rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule : mxbus_resp_mem
`default_nettype wire

// File: rtl/mxbus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mxbus_responder
//  Description : Target end of the MXBUS write protocol. Accepts a request,
//                acknowledges it after ACK_DELAY cycles, absorbs strobed data
//                beats into a register file and flags framing errors.
//  Ports       : clk, rst_n             clock, async active-low reset
//                start/address/length   request, sampled in IDLE
//                ready/dvalid           beat qualifier (beat = dvalid & ready)
//                data/strobe/complete   beat payload and last-beat marker
//                ack/busy/err           request pulse, activity, sticky error
//                rd_addr/rd_data        sideband read, 1-cycle latency
//  Revision    : 1.0  initial release
// ============================================================================
module mxbus_responder #(
    parameter int AW        = mxbus_pkg::AW,
    parameter int LW        = mxbus_pkg::LW,
    parameter int DW        = mxbus_pkg::DW,
    parameter int ACK_DELAY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW-1:0]   address,
    input  logic [LW-1:0]   length,
    input  logic            ready,
    input  logic            dvalid,
    input  logic [DW-1:0]   data,
    input  logic [DW/8-1:0] strobe,
    input  logic            complete,
    output logic            ack,
    output logic            busy,
    output logic            err,
    input  logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   rd_data
);

    import mxbus_pkg::*;

    // WAIT is left when the counter reaches this value, giving ACK_DELAY
    // cycles in WAIT. With ACK_DELAY == 0 WAIT is skipped entirely.
    localparam logic [2:0]    c_dly_last = (ACK_DELAY == 0) ? 3'd0 : 3'(ACK_DELAY - 1);
    localparam logic [AW-1:0] c_addr_one = 1;
    localparam logic [LW:0]   c_beat_one = 1;

    state_t        state_q, state_d;
    logic [2:0]    dly_q, dly_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [LW:0]   beats_left_q, beats_left_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic          beat_w;
    logic          last_w;
    logic          wr_en_w;

    assign beat_w = dvalid & ready;
    assign last_w = (beats_left_q == c_beat_one);

    always_comb begin
        state_d      = state_q;
        dly_d        = dly_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        err_d        = err_q;
        wr_en_w      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d   = address;
                    // Extra MSB makes length 0 mean 2**LW beats.
                    beats_left_d = {length == '0, length};
                    err_d        = 1'b0;
                    dly_d        = 3'd0;
                    state_d      = (ACK_DELAY == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (dly_q == c_dly_last) begin
                    state_d = ACK;
                end else begin
                    dly_d = dly_q + 3'd1;
                end
            end
            ACK: begin
                state_d = DATA;
            end
            DATA: begin
                if (beat_w) begin
                    // The terminating beat is written even when it is a framing error.
                    wr_en_w      = 1'b1;
                    cur_addr_d   = cur_addr_q + c_addr_one;
                    beats_left_d = beats_left_q - c_beat_one;
                    if (last_w) begin
                        err_d   = ~complete;
                        state_d = DONE;
                    end else if (complete) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs registered alongside the state they describe.
        ack_d  = (state_d == ACK);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dly_q        <= '0;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign ack  = ack_q;
    assign busy = busy_q;
    assign err  = err_q;

    mxbus_resp_mem #(
        .AW (AW),
        .DW (DW)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en_w),
        .wr_addr   (cur_addr_q),
        .wr_data   (data),
        .wr_strobe (strobe),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

endmodule : mxbus_responder
`default_nettype wire

// File: tb/tb_mxbus_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mxbus_responder
//  Description : Self-checking bench for mxbus_responder. A transaction-level
//                model (plain array of words) tracks expected memory, error
//                and ack timing while randomised beats, stalls and strobes
//                are driven.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mxbus_responder;

    localparam int AW        = 6;
    localparam int LW        = 6;
    localparam int DW        = 32;
    localparam int SW        = DW / 8;
    localparam int DEPTH     = 2 ** AW;
    localparam int ACK_DELAY = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] address;
    logic [LW-1:0] length;
    logic          ready;
    logic          dvalid;
    logic [DW-1:0] data;
    logic [SW-1:0] strobe;
    logic          complete;
    logic          ack;
    logic          busy;
    logic          err;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    always #5 clk = ~clk;

    mxbus_responder #(
        .AW        (AW),
        .LW        (LW),
        .DW        (DW),
        .ACK_DELAY (ACK_DELAY)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .address  (address),
        .length   (length),
        .ready    (ready),
        .dvalid   (dvalid),
        .data     (data),
        .strobe   (strobe),
        .complete (complete),
        .ack      (ack),
        .busy     (busy),
        .err      (err),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    // Reference state
    logic [DW-1:0] mem_m [DEPTH];
    logic          exp_err_g;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        start    = 1'b0;
        dvalid   = 1'b0;
        ready    = 1'b0;
        complete = 1'b0;
        data     = '0;
        strobe   = '0;
    endtask

    task automatic readback_all(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(i);
            @(negedge clk);
            check_eq($sformatf("%s[%0d]", tag, i), rd_data, mem_m[i]);
        end
    endtask

    // One request. cpl_at: 1-based beat carrying complete (0 = never).
    // dmode: 0 random, 1 beat index, 2 dfix. smode: 0 all ones, 1 random, 2 sfix.
    // abort_at > 0: assert reset after that many beats.
    task automatic do_txn(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                          input int cpl_at, input int stall_pct,
                          input int dmode, input logic [DW-1:0] dfix,
                          input int smode, input logic [SW-1:0] sfix,
                          input int abort_at);
        int            nbeats;
        int            last;
        int            k;
        int            done;
        int            cyc;
        bit            got_ack;
        bit            is_beat;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [DW-1:0] exp_rd;
        logic          exp_err;

        nbeats  = (len == '0) ? DEPTH : int'(len);
        last    = (cpl_at >= 1 && cpl_at <= nbeats) ? cpl_at : nbeats;
        exp_err = (cpl_at != nbeats);

        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("err_sticky", 32'(err), 32'(exp_err_g));

        start   = 1'b1;
        address = addr;
        length  = len;
        @(negedge clk);
        start   = 1'b0;
        address = AW'($urandom);
        length  = LW'($urandom);
        check_eq("busy_after_start", 32'(busy), 32'd1);
        check_eq("err_cleared", 32'(err), 32'd0);

        k = 1;
        got_ack = 1'b0;
        while (k <= 20 && !got_ack) begin
            if (ack) begin
                got_ack = 1'b1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        check_eq("ack_latency", 32'(k), 32'(ACK_DELAY + 1));
        if (!got_ack) begin
            drive_idle();
            return;
        end

        // A beat presented during the ack cycle must be ignored.
        dvalid   = 1'b1;
        ready    = 1'b1;
        complete = 1'b1;
        data     = $urandom;
        strobe   = '1;
        rd_addr  = addr;
        exp_rd   = mem_m[addr];

        a    = addr;
        done = 0;
        cyc  = 0;
        while (done < last && !(abort_at > 0 && done >= abort_at) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            check_eq("rd_before_write", rd_data, exp_rd);
            check_eq("no_reack", 32'(ack), 32'd0);
            check_eq("busy_data", 32'(busy), 32'd1);

            is_beat = ($urandom_range(99) >= stall_pct);
            start   = ($urandom_range(3) == 0);
            if (is_beat) begin
                dvalid = 1'b1;
                ready  = 1'b1;
            end else begin
                case ($urandom_range(2))
                    0:       begin dvalid = 1'b0; ready = 1'b0; end
                    1:       begin dvalid = 1'b1; ready = 1'b0; end
                    default: begin dvalid = 1'b0; ready = 1'b1; end
                endcase
            end
            d = (dmode == 0) ? DW'($urandom) : (dmode == 1) ? DW'(done) : dfix;
            s = (smode == 0) ? '1 : (smode == 1) ? SW'($urandom) : sfix;
            data    = d;
            strobe  = s;
            rd_addr = a;
            exp_rd  = mem_m[a];
            if (is_beat) begin
                complete = (done + 1 == cpl_at);
                for (int b = 0; b < SW; b++) begin
                    if (s[b]) mem_m[a][b*8 +: 8] = d[b*8 +: 8];
                end
                a = a + 1'b1;
                done++;
            end else begin
                complete = 1'($urandom_range(1));
            end
        end

        if (abort_at > 0) begin
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check_eq("rst_ack", 32'(ack), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_err", 32'(err), 32'd0);
            check_eq("rst_rd_data", rd_data, 32'd0);
            drive_idle();
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            exp_err_g = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
        end

        check_eq("beat_count", 32'(done), 32'(last));

        @(negedge clk);
        drive_idle();
        check_eq("rd_before_write", rd_data, exp_rd);
        check_eq("busy_done", 32'(busy), 32'd1);
        check_eq("err_done", 32'(err), 32'(exp_err));
        check_eq("no_reack", 32'(ack), 32'd0);

        @(negedge clk);
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("err_idle", 32'(err), 32'(exp_err));
        check_eq("ack_idle", 32'(ack), 32'd0);
        exp_err_g = exp_err;
    endtask

    initial begin
        logic [LW-1:0] rl;
        int            rnb;
        int            rcp;

        drive_idle();
        rst_n     = 1'b0;
        address   = '0;
        length    = '0;
        rd_addr   = '0;
        exp_err_g = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

        repeat (3) @(negedge clk);
        check_eq("reset_ack", 32'(ack), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_err", 32'(err), 32'd0);
        check_eq("reset_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        readback_all("reset_mem");

        // Basic three-beat burst
        do_txn(6'd5, 6'd3, 3, 0, 0, '0, 0, '0, 0);
        readback_all("basic");

        // 64-beat burst wrapping past the top of the array
        do_txn(6'd62, 6'd0, 64, 0, 1, '0, 0, '0, 0);
        readback_all("wrap");

        // Byte-strobe merge
        do_txn(6'd10, 6'd1, 1, 0, 2, 32'hFFFF_FFFF, 0, '0, 0);
        do_txn(6'd10, 6'd1, 1, 0, 2, 32'h1122_3344, 2, 4'b0101, 0);
        rd_addr = 6'd10;
        @(negedge clk);
        check_eq("strobe_merge", rd_data, 32'hFF22_FF44);

        // Stalled burst and all-zero strobes
        do_txn(6'd30, 6'd5, 5, 60, 0, '0, 1, '0, 0);
        do_txn(6'd40, 6'd2, 2, 0, 0, '0, 2, 4'b0000, 0);
        readback_all("stall_strobe");

        // Framing errors, then a clean request clears err
        do_txn(6'd50, 6'd4, 2, 20, 0, '0, 0, '0, 0);
        do_txn(6'd8, 6'd2, 0, 20, 0, '0, 0, '0, 0);
        do_txn(6'd1, 6'd1, 1, 0, 0, '0, 0, '0, 0);
        readback_all("framing");

        // Randomised requests
        repeat (12) begin
            rl  = LW'($urandom);
            rnb = (rl == '0) ? DEPTH : int'(rl);
            case ($urandom_range(3))
                0:       rcp = $urandom_range(rnb, 1);
                1:       rcp = 0;
                default: rcp = rnb;
            endcase
            do_txn(AW'($urandom), rl, rcp, $urandom_range(60), 0, '0, 1, '0, 0);
            readback_all("random");
        end

        // Reset in the middle of the data phase
        do_txn(6'd20, 6'd8, 8, 20, 0, '0, 1, '0, 3);
        readback_all("mid_reset");
        do_txn(6'd2, 6'd2, 2, 0, 0, '0, 0, '0, 0);
        readback_all("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule : tb_mxbus_responder
`default_nettype wire
